// File: rtl/sky130_as_sc_hs__scan_reader.sv
// Scan reader: snapshots DIN on CAPTURE and streams it LSB-first over a valid/ready bit link.
// Optional even-parity trailer bit when SKY130_AS_SC_HS_SCAN_PARITY_EN is defined.
module sky130_as_sc_hs__scan_reader #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET_B,
    input  logic             CAPTURE,
    input  logic [WIDTH-1:0] DIN,
    input  logic             SREADY,
    output logic             SOUT,
    output logic             SVALID,
    output logic             SFIRST,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVERRUN,
    input  logic             VPWR,
    input  logic             VGND,
    input  logic             VPB,
    input  logic             VNB
);

`ifdef SKY130_AS_SC_HS_SCAN_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int              CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    // With parity enabled the stored parity rides in the top bit and reaches bit 0 last.
    logic [N-1:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [N-1:0]     load_val;
    logic             xfer;
    logic             last_xfer;
    logic             unused_supply;

`ifdef SKY130_AS_SC_HS_SCAN_PARITY_EN
    assign load_val = {^DIN, DIN};
`else
    assign load_val = DIN;
`endif

    assign xfer          = (state_q == SHIFT) && SREADY;
    assign last_xfer     = xfer && (cnt_q == LAST);
    assign unused_supply = ^{VPWR, VGND, VPB, VNB};

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (CAPTURE) begin
                    state_d   = SHIFT;
                    shadow_d  = load_val;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            SHIFT: begin
                if (last_xfer) begin
                    done_d = 1'b1;
                    if (CAPTURE) begin
                        shadow_d  = load_val;
                        cnt_d     = '0;
                        overrun_d = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        shadow_d = shadow_q >> 1;
                        cnt_d    = '0;
                    end
                end else begin
                    if (xfer) begin
                        shadow_d = shadow_q >> 1;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                    if (CAPTURE) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the shadow is reset along with control state so a reset leaves no stale frame data behind.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            state_q   <= IDLE;
            shadow_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign SVALID  = (state_q == SHIFT);
    assign BUSY    = (state_q == SHIFT);
    assign SOUT    = (state_q == SHIFT) && shadow_q[0];
    assign SFIRST  = (state_q == SHIFT) && (cnt_q == '0);
    assign DONE    = done_q;
    assign OVERRUN = overrun_q;

endmodule
